// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver for an HH:MM display.
// Each slot opens with an all-off dead time to stop ghosting between digits.
module seg7_scan_driver #(
   parameter int REFRESH_DIV = 100_000,
   parameter int DEAD_CYCLES = 1_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   input  logic [3:0] dp_in,
   input  logic       lz_blank,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] cnt;
   logic [1:0]    sel;
   logic          dead;
   logic [3:0]    digit;
   logic [3:0]    an_next;
   logic [6:0]    seg_next;
   logic          dp_next;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   // A zero-length dead time would otherwise become an always-false compare.
   if (DEAD_CYCLES == 0) begin : g_no_dead
      assign dead = 1'b0;
   end else begin : g_dead
      assign dead = (cnt < CW'(DEAD_CYCLES));
   end

   always_comb begin
      an_next  = 4'b1111;
      seg_next = 7'b1111111;
      dp_next  = 1'b1;
      case (sel)
         2'd0:    digit = d0;
         2'd1:    digit = d1;
         2'd2:    digit = d2;
         default: digit = d3;
      endcase
      if (!dead && !(sel == 2'd3 && lz_blank && digit == 4'd0)) begin
         an_next  = ~(4'b0001 << sel);
         seg_next = decode(digit);
         dp_next  = ~dp_in[sel];
      end
   end

   // Pins are registered from the pre-edge slot state, so an only ever shows one sel.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         sel <= 2'd0;
         an  <= 4'b1111;
         seg <= 7'b1111111;
         dp  <= 1'b1;
      end else begin
         if (cnt == LAST) begin
            cnt <= '0;
            sel <= sel + 2'd1;
         end else begin
            cnt <= cnt + CW'(1);
         end
         an  <= an_next;
         seg <= seg_next;
         dp  <= dp_next;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver: two instances (with and without dead time)
// compared every cycle against a slot-arithmetic reference model.
module tb_seg7_scan_driver;

   logic       clk;
   logic       rst;
   logic [3:0] d0, d1, d2, d3;
   logic [3:0] dp_in;
   logic       lz_blank;
   logic [3:0] an_a, an_b;
   logic [6:0] seg_a, seg_b;
   logic       dp_a, dp_b;

   int n_checks = 0;
   int n_pass   = 0;

   logic [6:0] seg_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
      7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
   };

   seg7_scan_driver #(.REFRESH_DIV(4), .DEAD_CYCLES(1)) dut_a (
      .clk(clk), .rst(rst), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .dp_in(dp_in), .lz_blank(lz_blank), .an(an_a), .seg(seg_a), .dp(dp_a)
   );

   seg7_scan_driver #(.REFRESH_DIV(5), .DEAD_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .dp_in(dp_in), .lz_blank(lz_blank), .an(an_b), .seg(seg_b), .dp(dp_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("[TB] FAIL %s got=%0h exp=%0h (check %0d)", tag, got, exp, n_checks);
   endtask

   // k counts edges since reset release; expected pins are {an, seg, dp}.
   function automatic logic [11:0] model(input int k, input int r, input int dc,
                                          input logic [15:0] dg, input logic [3:0] dpi,
                                          input logic lz);
      int pos, slot;
      logic [3:0] digit, an_e;
      pos   = k % r;
      slot  = (k / r) % 4;
      digit = dg[slot*4 +: 4];
      if (pos < dc) return {4'b1111, 7'b1111111, 1'b1};
      if (slot == 3 && lz && digit == 4'd0) return {4'b1111, 7'b1111111, 1'b1};
      an_e = 4'b1111;
      an_e[slot] = 1'b0;
      return {an_e, seg_tab[digit], ~dpi[slot]};
   endfunction

   task automatic applyStimulus();
      d0 = 4'($urandom_range(0, 15));
      d1 = 4'($urandom_range(0, 15));
      d2 = 4'($urandom_range(0, 15));
      d3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      dp_in    = 4'($urandom_range(0, 15));
      lz_blank = 1'($urandom_range(0, 1));
      rst      = ($urandom_range(0, 299) == 0);
   endtask

   initial begin
      logic [11:0] exp_a, exp_b;
      int k;
      rst = 1'b1;
      d0 = 4'd0; d1 = 4'd0; d2 = 4'd0; d3 = 4'd0;
      dp_in = 4'd0; lz_blank = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_an",  32'(an_a),  32'hF);
      checkOutput("reset_seg", 32'(seg_a), 32'h7F);
      checkOutput("reset_dp",  32'(dp_a),  32'h1);
      checkOutput("reset_an_b", 32'(an_b), 32'hF);

      k = 0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         applyStimulus();
         if (rst) begin
            exp_a = {4'b1111, 7'b1111111, 1'b1};
            exp_b = exp_a;
            k = 0;
         end else begin
            exp_a = model(k, 4, 1, {d3, d2, d1, d0}, dp_in, lz_blank);
            exp_b = model(k, 5, 0, {d3, d2, d1, d0}, dp_in, lz_blank);
            k++;
         end
         @(posedge clk);
         #1;
         checkOutput("an_a",  32'(an_a),  32'(exp_a[11:8]));
         checkOutput("seg_a", 32'(seg_a), 32'(exp_a[7:1]));
         checkOutput("dp_a",  32'(dp_a),  32'(exp_a[0]));
         checkOutput("an_b",  32'(an_b),  32'(exp_b[11:8]));
         checkOutput("seg_b", 32'(seg_b), 32'(exp_b[7:1]));
         checkOutput("dp_b",  32'(dp_b),  32'(exp_b[0]));
         checkOutput("onehot_a", 32'($countones(~an_a) <= 1), 32'd1);
         checkOutput("onehot_b", 32'($countones(~an_b) <= 1), 32'd1);
      end

      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
